// File: rtl/aero_spi_pkg.sv
// Shared definitions for the AEROFC SPI register bank: register addresses,
// FSM state encoding and the write-permission rule.
package aero_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [6:0] ADDR_VERSION = 7'h00;
    localparam logic [6:0] ADDR_BOOT    = 7'h01;
    localparam logic [6:0] ADDR_SCRATCH = 7'h02;
    localparam logic [6:0] ADDR_ERR_CNT = 7'h03;

    function automatic logic is_writable(input logic [6:0] addr);
        return (addr == ADDR_BOOT) || (addr == ADDR_SCRATCH);
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Byte-level link between the SPI slave shifter and the register bank.
interface spi_reg_bank_if;
    logic       transaction_begin;
    logic       rx_byte_available;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       bootloader_force;
    logic [7:0] scratch;
    logic [7:0] err_count;
    logic       wr_strobe;

    modport master (
        output transaction_begin, rx_byte_available, rx_byte,
        input  tx_byte, bootloader_force, scratch, err_count, wr_strobe
    );

    modport slave (
        input  transaction_begin, rx_byte_available, rx_byte,
        output tx_byte, bootloader_force, scratch, err_count, wr_strobe
    );
endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for a level that is already synchronous to clk.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic din_d, din_q;
    logic armed_d, armed_q;

    always_comb begin
        din_d   = din;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            din_q   <= din_d;
            armed_q <= armed_d;
        end
    end

    // armed_q masks the first cycle after reset so a level held high across
    // reset release never looks like a fresh byte.
    assign rise = din & ~din_q & armed_q;
endmodule

// File: rtl/spi_reg_bank.sv
// AEROFC SPI register bank: address byte then a burst of data bytes,
// read or write, with a saturating counter of rejected writes.
module spi_reg_bank
    import aero_spi_pkg::*;
#(
    parameter logic [7:0] FPGA_VER = 8'hC1,
    parameter logic [7:0] ERR_SAT  = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    spi_reg_bank_if.slave  bus
);
    logic       byte_evt;
    state_t     state_d, state_q;
    logic [6:0] addr_d, addr_q, addr_next;
    logic       dir_d, dir_q;
    logic [7:0] tx_d, tx_q;
    logic       boot_d, boot_q;
    logic [7:0] scratch_d, scratch_q;
    logic [7:0] err_d, err_q;
    logic       strobe_d, strobe_q;

    function automatic logic [7:0] read_reg(input logic [6:0] a, input logic boot,
                                            input logic [7:0] scr, input logic [7:0] err);
        case (a)
            ADDR_VERSION: return FPGA_VER;
            ADDR_BOOT:    return {7'b0, boot};
            ADDR_SCRATCH: return scr;
            ADDR_ERR_CNT: return err;
            default:      return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

    edge_detect_rise u_rx_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.rx_byte_available),
        .rise  (byte_evt)
    );

    assign addr_next = addr_q + 7'd1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dir_d     = dir_q;
        tx_d      = tx_q;
        boot_d    = boot_q;
        scratch_d = scratch_q;
        err_d     = err_q;
        strobe_d  = 1'b0;
        // A new transaction overrides any byte arriving in the same cycle.
        if (bus.transaction_begin) begin
            state_d = ST_ADDR;
            tx_d    = 8'h00;
        end else if (byte_evt) begin
            case (state_q)
                ST_ADDR: begin
                    addr_d  = bus.rx_byte[6:0];
                    dir_d   = bus.rx_byte[7];
                    state_d = ST_DATA;
                    if (!bus.rx_byte[7])
                        tx_d = read_reg(bus.rx_byte[6:0], boot_q, scratch_q, err_q);
                end
                ST_DATA: begin
                    addr_d = addr_next;
                    if (dir_q) begin
                        if (is_writable(addr_q)) begin
                            strobe_d = 1'b1;
                            if (addr_q == ADDR_BOOT)
                                boot_d = bus.rx_byte[0];
                            else
                                scratch_d = bus.rx_byte;
                        end else begin
                            err_d = sat_inc(err_q);
                        end
                    end else begin
                        tx_d = read_reg(addr_next, boot_q, scratch_q, err_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 7'h00;
            dir_q     <= 1'b0;
            tx_q      <= 8'h00;
            boot_q    <= 1'b0;
            scratch_q <= 8'h00;
            err_q     <= 8'h00;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dir_q     <= dir_d;
            tx_q      <= tx_d;
            boot_q    <= boot_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
            strobe_q  <= strobe_d;
        end
    end

    assign bus.tx_byte          = tx_q;
    assign bus.bootloader_force = boot_q;
    assign bus.scratch          = scratch_q;
    assign bus.err_count        = err_q;
    assign bus.wr_strobe        = strobe_q;
endmodule
